// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command engine.
// State encoding, command indices, token and R1 bit layout.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_CHECK,
        ST_ISSUE,
        ST_XFER
    } state_t;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD1  = 6'd1;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;

    localparam logic [7:0] TOKEN = 8'hFE;
    localparam logic [7:0] FILL  = 8'hFF;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [7:0] r1_pack(
        input logic idle,
        input logic illegal,
        input logic crc_err
    );
        logic [7:0] r;
        r = '0;
        r[R1_IDLE]    = idle;
        r[R1_ILLEGAL] = illegal;
        r[R1_CRC_ERR] = crc_err;
        return r;
    endfunction

endpackage

// File: rtl/crc7_byte.sv
// One-byte CRC7 step (x^7 + x^3 + 1), MSB of the byte first.
// Purely combinational; the caller holds the running state.
module crc7_byte
    import sd_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic [7:0] data,
    output logic [6:0] crc_out
);

    logic fb;

    // shift the byte through the LFSR one bit at a time
    always_comb begin
        crc_out = crc_in;
        fb      = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb      = crc_out[6] ^ data[i];
            crc_out = {crc_out[5:0], 1'b0};
            if (fb) begin
                crc_out = crc_out ^ CRC7_POLY;
            end
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD-over-SPI command engine: checks a command frame, answers
// with R1 and moves one data block between SPI and a local buffer.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int COMMAND_SIZE         = 6,
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int BLOCK_BYTES          = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [8*COMMAND_SIZE-1:0]               cmd,
    input  logic                                    transfer,
    output logic                                    start,
    output logic                                    op,
    output logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] size,
    input  logic                                    done,
    input  logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] address,
    input  logic                                    wr,
    input  logic [7:0]                              data_out,
    output logic [7:0]                              data_in,
    input  logic                                    host_we,
    input  logic [$clog2(BLOCK_BYTES)-1:0]          host_addr,
    input  logic [7:0]                              host_wdata,
    output logic [7:0]                              host_rdata,
    output logic [31:0]                             arg,
    output logic [7:0]                              r1,
    output logic                                    busy,
    output logic                                    token_err
);

    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam int BW = $clog2(BLOCK_BYTES);
    localparam int CW = $clog2(COMMAND_SIZE);

    state_t state;
    state_t state_nxt;

    logic [8*COMMAND_SIZE-1:0] cmd_q;
    logic [CW-1:0]             cnt;
    logic [6:0]                crc_q;
    logic [6:0]                crc_nxt;
    logic [7:0]                crc_byte;

    logic          op_q;
    logic [AW-1:0] size_q;
    logic [7:0]    r1_q;
    logic          idle_q;
    logic [31:0]   arg_q;
    logic          tok_q;

    logic [7:0] mem [BLOCK_BYTES];

    logic          frame_ok;
    logic [5:0]    idx;
    logic [31:0]   frame_arg;
    logic          d_op;
    logic [AW-1:0] d_size;
    logic          d_idle;
    logic          d_ill;
    logic          d_crc_err;
    logic          d_tok_clr;
    logic [7:0]    d_r1;

    logic          spi_wr;
    logic          spi_buf_wr;
    logic          tok_bad;
    logic [BW-1:0] wr_idx;
    logic [BW-1:0] rd_idx;
    logic          in_blk;
    logic          send_on;

    crc7_byte u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_nxt)
    );

    assign idx       = cmd_q[5:0];
    assign frame_arg = {cmd_q[15:8], cmd_q[23:16],
                        cmd_q[31:24], cmd_q[39:32]};
    assign frame_ok  = (cmd_q[7:6] == 2'b01)
                    && cmd_q[8*(COMMAND_SIZE-1)]
                    && (cmd_q[8*COMMAND_SIZE-1 -: 7] == crc_q);

    assign spi_wr     = (state == ST_XFER) && !op_q && wr;
    assign spi_buf_wr = spi_wr && (address != '0)
                     && (address <= AW'(BLOCK_BYTES));
    assign tok_bad    = spi_wr && (address == '0)
                     && (data_out != TOKEN);
    assign wr_idx     = BW'(address - AW'(1));
    assign rd_idx     = BW'(address - AW'(2));
    assign in_blk     = (address >= AW'(2))
                     && (address <= AW'(BLOCK_BYTES + 1));
    assign send_on    = op_q
                     && ((state == ST_ISSUE) || (state == ST_XFER));

    assign host_rdata = mem[host_addr];
    assign op         = op_q;
    assign size       = size_q;
    assign r1         = r1_q;
    assign arg        = arg_q;
    assign token_err  = tok_q;

    // FSM state register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: fixed CRC/check/issue pipeline, then wait for done
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (transfer) begin
                    state_nxt = ST_CRC;
                end
            end
            ST_CRC: begin
                if (cnt == CW'(COMMAND_SIZE - 2)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_XFER;
            ST_XFER: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: go pulse, busy flag and the byte offered to SPI
    always_comb begin
        start = (state == ST_ISSUE);
        busy  = (state != ST_IDLE);
        if (!send_on) begin
            data_in = FILL;
        end else begin
            unique case (1'b1)
                (address == AW'(0)): data_in = r1_q;
                (address == AW'(1)): data_in = TOKEN;
                in_blk:              data_in = mem[rd_idx];
                default:             data_in = FILL;
            endcase
        end
    end

    // pick the command byte the CRC walks over this cycle
    always_comb begin
        crc_byte = '0;
        for (int i = 0; i < COMMAND_SIZE; i++) begin
            if (int'(cnt) == i) begin
                crc_byte = cmd_q[8*i +: 8];
            end
        end
    end

    // latch the frame and run the CRC over the leading bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            cnt   <= '0;
            crc_q <= '0;
        end else if (state == ST_IDLE && transfer) begin
            cmd_q <= cmd;
            cnt   <= '0;
            crc_q <= '0;
        end else if (state == ST_CRC) begin
            cnt   <= cnt + CW'(1);
            crc_q <= crc_nxt;
        end
    end

    // decode the checked frame into response and transfer setup
    always_comb begin
        d_op      = 1'b1;
        d_size    = '0;
        d_idle    = idle_q;
        d_ill     = 1'b0;
        d_crc_err = 1'b0;
        d_tok_clr = 1'b0;
        unique case (1'b1)
            !frame_ok: d_crc_err = 1'b1;
            frame_ok && (idx == CMD0): d_idle = 1'b1;
            frame_ok && (idx == CMD1): d_idle = 1'b0;
            frame_ok && (idx == CMD17) && !idle_q: begin
                d_size = AW'(BLOCK_BYTES + 1);
            end
            frame_ok && (idx == CMD24) && !idle_q: begin
                d_op      = 1'b0;
                d_size    = AW'(BLOCK_BYTES);
                d_tok_clr = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        d_r1 = r1_pack(d_idle, d_ill, d_crc_err);
    end

    // response registers: set once per frame, token error is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            size_q <= '0;
            r1_q   <= r1_pack(1'b1, 1'b0, 1'b0);
            idle_q <= 1'b1;
            arg_q  <= '0;
            tok_q  <= 1'b0;
        end else if (state == ST_CHECK) begin
            op_q   <= d_op;
            size_q <= d_size;
            r1_q   <= d_r1;
            idle_q <= d_idle;
            if (frame_ok) begin
                arg_q <= frame_arg;
            end
            if (d_tok_clr) begin
                tok_q <= 1'b0;
            end
        end else if (tok_bad) begin
            tok_q <= 1'b1;
        end
    end

    // block buffer: SPI write has priority, host write is dropped
    always_ff @(posedge clk) begin
        if (spi_buf_wr) begin
            mem[wr_idx] <= data_out;
        end else if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a transaction-level
// reference model checked every cycle plus literal expectations.
module tb_sd_cmd_engine;

    localparam int CS = 6;
    localparam int MS = 64;
    localparam int BB = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] cmd;
    logic        transfer;
    logic        start;
    logic        op;
    logic [5:0]  size;
    logic        done;
    logic [5:0]  address;
    logic        wr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic        busy;
    logic        token_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_cmd_engine #(
        .COMMAND_SIZE         (CS),
        .MEMORY_SIZE_IN_BYTES (MS),
        .BLOCK_BYTES          (BB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .transfer   (transfer),
        .start      (start),
        .op         (op),
        .size       (size),
        .done       (done),
        .address    (address),
        .wr         (wr),
        .data_out   (data_out),
        .data_in    (data_in),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .arg        (arg),
        .r1         (r1),
        .busy       (busy),
        .token_err  (token_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // CRC7 as polynomial remainder of M(x)*x^7 mod (x^7+x^3+1)
    function automatic logic [6:0] crc7_ref(input logic [47:0] f);
        logic [46:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v[46-8*i -: 8] = f[8*i +: 8];
        for (int b = 46; b >= 7; b--)
            if (v[b]) v[b -: 8] = v[b -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] b0, b1, b2,
                                       b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [47:0] mk_ok(input logic [7:0] b0, b1,
                                          b2, b3, b4);
        logic [47:0] f;
        f = mk(b0, b1, b2, b3, b4, 8'h00);
        f[47:40] = {crc7_ref(f), 1'b1};
        return f;
    endfunction

    // reference model: m_cnt = -1 idle, 1..6 busy, 7 start, 8 transfer
    int          m_cnt;
    logic        m_idle;
    logic [7:0]  m_r1;
    logic [31:0] m_arg;
    logic        m_tok;
    logic        m_op;
    logic [5:0]  m_size;
    logic [47:0] m_frame;
    logic [7:0]  m_mem [BB];
    bit          m_known [BB];

    task automatic model_reset();
        m_cnt = -1; m_idle = 1'b1; m_r1 = 8'h01; m_arg = '0;
        m_tok = 1'b0; m_op = 1'b0; m_size = '0; m_frame = '0;
    endtask

    task automatic apply_frame();
        logic [7:0] b0, b5;
        logic ok;
        b0 = m_frame[7:0];
        b5 = m_frame[47:40];
        ok = (b0[7:6] == 2'b01) && b5[0]
          && (b5[7:1] == crc7_ref(m_frame));
        m_op = 1'b1;
        m_size = '0;
        if (!ok) begin
            m_r1 = 8'h08 | {7'b0, m_idle};
        end else begin
            m_arg = {m_frame[15:8], m_frame[23:16],
                     m_frame[31:24], m_frame[39:32]};
            if (b0[5:0] == 6'd0) begin
                m_idle = 1'b1; m_r1 = 8'h01;
            end else if (b0[5:0] == 6'd1) begin
                m_idle = 1'b0; m_r1 = 8'h00;
            end else if (b0[5:0] == 6'd17 && !m_idle) begin
                m_size = 6'(BB + 1); m_r1 = 8'h00;
            end else if (b0[5:0] == 6'd24 && !m_idle) begin
                m_op = 1'b0; m_size = 6'(BB); m_tok = 1'b0;
                m_r1 = 8'h00;
            end else begin
                m_r1 = 8'h04 | {7'b0, m_idle};
            end
        end
    endtask

    task automatic model_step();
        bit spi_hit;
        spi_hit = 0;
        if (m_cnt < 0) begin
            if (transfer) begin m_frame = cmd; m_cnt = 1; end
        end else if (m_cnt < 7) begin
            m_cnt++;
            if (m_cnt == 7) apply_frame();
        end else if (m_cnt == 7) begin
            m_cnt = 8;
        end else begin
            if (wr && !m_op) begin
                if (address == 0) begin
                    if (data_out != 8'hFE) m_tok = 1'b1;
                end else if (int'(address) <= BB) begin
                    m_mem[int'(address) - 1] = data_out;
                    m_known[int'(address) - 1] = 1;
                    spi_hit = 1;
                end
            end
            if (done) m_cnt = -1;
        end
        if (host_we && !spi_hit) begin
            m_mem[host_addr] = host_wdata;
            m_known[host_addr] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // compare process: every cycle out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                logic [7:0] e;
                bit kn;
                chk("busy", busy, m_cnt > 0);
                chk("start", start, m_cnt == 7);
                chk("op", op, m_op);
                chk("size", size, m_size);
                chk("r1", r1, m_r1);
                chk("arg", arg, m_arg);
                chk("token_err", token_err, m_tok);
                e = 8'hFF;
                kn = 1;
                if (m_cnt >= 7 && m_op) begin
                    if (address == 0) e = m_r1;
                    else if (address == 1) e = 8'hFE;
                    else if (int'(address) <= BB + 1) begin
                        kn = m_known[int'(address) - 2];
                        e = m_mem[int'(address) - 2];
                    end
                end
                if (kn) chk("data_in", data_in, e);
                if (m_known[host_addr])
                    chk("host_rdata", host_rdata, m_mem[host_addr]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] f, input string nm);
        int lat;
        cmd = f;
        transfer = 1'b1;
        tick();
        transfer = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!start && lat < 20);
        chk({nm, "_start_latency"}, lat, 7);
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp,
                      input string nm);
        address = a;
        @(negedge clk);
        chk(nm, data_in, exp);
        tick();
    endtask

    task automatic finish_xfer();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] f;
        rst_n = 1'b0; cmd = '0; transfer = 0; done = 0; address = '0;
        wr = 0; data_out = '0; host_we = 0; host_addr = '0;
        host_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_op", op, 0);
        chk("rst_size", size, 0);
        chk("rst_r1", r1, 8'h01);
        chk("rst_arg", arg, 0);
        chk("rst_token", token_err, 0);
        chk("rst_data_in", data_in, 8'hFF);
        tick();
        rst_n = 1'b1;

        chk("crc_cmd0", crc7_ref(mk(8'h40, 0, 0, 0, 0, 0)), 7'h4A);
        chk("crc_cmd1", crc7_ref(mk(8'h41, 0, 0, 0, 0, 0)), 7'h7C);
        chk("crc_cmd17", crc7_ref(mk(8'h51, 0, 0, 0, 0, 0)), 7'h2A);
        chk("crc_cmd24", crc7_ref(mk(8'h58, 0, 0, 0, 0, 0)), 7'h37);
        tick();

        send_frame(mk(8'h40, 0, 0, 0, 0, 8'h95), "cmd0");
        chk("cmd0_op", op, 1);
        chk("cmd0_size", size, 0);
        chk("cmd0_r1", r1, 8'h01);
        tick();
        rd(6'd0, 8'h01, "cmd0_send_r1");
        finish_xfer();
        @(negedge clk);
        chk("cmd0_busy_after", busy, 0);
        tick();

        send_frame(mk(8'h41, 0, 0, 0, 0, 8'hF9), "cmd1");
        chk("cmd1_r1", r1, 8'h00);
        tick();
        finish_xfer();

        for (int i = 0; i < BB; i++) begin
            host_we = 1'b1;
            host_addr = 5'(i);
            host_wdata = 8'hA0 + 8'(i);
            tick();
        end
        host_we = 1'b0;
        host_addr = 5'd3;
        @(negedge clk);
        chk("host_rd3", host_rdata, 8'hA3);
        tick();
        wr = 1'b1; address = 6'd0; data_out = 8'h00;
        tick();
        wr = 1'b0;
        @(negedge clk);
        chk("idle_wr_token", token_err, 0);
        tick();

        send_frame(mk(8'h51, 0, 0, 0, 0, 8'h55), "cmd17");
        chk("cmd17_op", op, 1);
        chk("cmd17_size", size, 33);
        chk("cmd17_r1", r1, 8'h00);
        tick();
        rd(6'd0, 8'h00, "cmd17_addr0");
        rd(6'd1, 8'hFE, "cmd17_addr1");
        rd(6'd2, 8'hA0, "cmd17_addr2");
        rd(6'd33, 8'hBF, "cmd17_addr33");
        rd(6'd34, 8'hFF, "cmd17_addr34");
        rd(6'd63, 8'hFF, "cmd17_addr63");
        wr = 1'b1; address = 6'd2; data_out = 8'h99;
        tick();
        wr = 1'b0;
        cmd = mk(8'h40, 0, 0, 0, 0, 8'h95);
        transfer = 1'b1;
        tick();
        transfer = 1'b0;
        rd(6'd2, 8'hA0, "cmd17_after_ignored_wr");
        finish_xfer();
        host_addr = 5'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("host_rd0_kept", host_rdata, 8'hA0);
        chk("r1_after_ignored_cmd0", r1, 8'h00);
        chk("busy_after_ignored", busy, 0);
        tick();

        send_frame(mk(8'h58, 0, 0, 0, 0, 8'h6F), "cmd24");
        chk("cmd24_op", op, 0);
        chk("cmd24_size", size, 32);
        tick();
        wr = 1'b1;
        for (int i = 0; i <= BB; i++) begin
            address = 6'(i);
            data_out = (i == 0) ? 8'hFE : 8'(i - 1);
            if (i == BB) begin
                host_we = 1'b1; host_addr = 5'd31; host_wdata = 8'h77;
            end
            tick();
        end
        wr = 1'b0;
        host_we = 1'b0;
        finish_xfer();
        @(negedge clk);
        chk("spi_wins_31", host_rdata, 8'h1F);
        chk("cmd24_token", token_err, 0);
        tick();
        host_addr = 5'd5;
        @(negedge clk);
        chk("cmd24_buf5", host_rdata, 8'h05);
        tick();

        send_frame(mk_ok(8'h77, 8'h12, 8'h34, 8'h56, 8'h78), "cmd55");
        chk("cmd55_r1", r1, 8'h04);
        chk("cmd55_arg", arg, 32'h12345678);
        tick();
        finish_xfer();
        f = mk_ok(8'h51, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        f[41] = ~f[41];
        send_frame(f, "badcrc");
        chk("badcrc_r1", r1, 8'h08);
        chk("badcrc_arg", arg, 32'h12345678);
        chk("badcrc_size", size, 0);
        tick();
        finish_xfer();
        send_frame(mk_ok(8'h11, 0, 0, 0, 0), "badstart");
        chk("badstart_r1", r1, 8'h08);
        tick();
        finish_xfer();

        send_frame(mk(8'h58, 0, 0, 0, 0, 8'h6F), "cmd24_bad");
        tick();
        wr = 1'b1; address = 6'd0; data_out = 8'hAA;
        tick();
        wr = 1'b0;
        @(negedge clk);
        chk("token_set", token_err, 1);
        tick();
        wr = 1'b1; address = 6'd1; data_out = 8'h3C;
        tick();
        wr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_start", start, 0);
        chk("abort_token", token_err, 0);
        chk("abort_r1", r1, 8'h01);
        tick();
        rst_n = 1'b1;
        tick();

        send_frame(mk(8'h51, 0, 0, 0, 0, 8'h55), "cmd17_idle");
        chk("cmd17_idle_r1", r1, 8'h05);
        chk("cmd17_idle_size", size, 0);
        tick();
        finish_xfer();
        send_frame(mk(8'h40, 0, 0, 0, 0, 8'h97), "cmd0_bad");
        chk("cmd0_bad_r1", r1, 8'h09);
        chk("cmd0_bad_size", size, 0);
        chk("cmd0_bad_arg", arg, 0);
        tick();
        finish_xfer();

        send_frame(mk(8'h41, 0, 0, 0, 0, 8'hF9), "cmd1_b");
        tick();
        finish_xfer();
        send_frame(mk(8'h58, 0, 0, 0, 0, 8'h6F), "cmd24_b");
        tick();
        wr = 1'b1; address = 6'd0; data_out = 8'hAA;
        tick();
        wr = 1'b0;
        finish_xfer();
        send_frame(mk(8'h51, 0, 0, 0, 0, 8'h55), "cmd17_b");
        chk("token_sticky", token_err, 1);
        tick();
        finish_xfer();
        send_frame(mk(8'h58, 0, 0, 0, 0, 8'h6F), "cmd24_c");
        chk("token_cleared", token_err, 0);
        tick();
        finish_xfer();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
